// File: rtl/uart_pkg.sv
// UART transmit shared types and constants: FSM state encoding, data-width limits, line idle level.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam int   MIN_DATA   = 5;
    localparam int   MAX_DATA   = 8;
    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_transmitter_if.sv
// Host-side request/config bundle plus serial line and status for the UART transmitter.
// Latency: n/a (wires only).
// Backpressure: tx_start is honoured only while tx_ready is high; requests while busy are dropped.
interface uart_transmitter_if #(
    parameter int PERIOD_BITS = 14,
    parameter int MAX_DATA    = 8
);
    logic [MAX_DATA-1:0]    tx_data;
    logic [3:0]             data_size;
    logic [PERIOD_BITS-1:0] bit_period;
    logic                   parity_en;
    logic                   tx_start;
    logic                   tx_ready;
    logic                   serial_out;
    logic                   tx_busy;
    logic                   tx_done;

    modport master (
        output tx_data, data_size, bit_period, parity_en, tx_start,
        input  tx_ready, serial_out, tx_busy, tx_done
    );

    modport slave (
        input  tx_data, data_size, bit_period, parity_en, tx_start,
        output tx_ready, serial_out, tx_busy, tx_done
    );
endinterface

// File: rtl/uart_transmitter_bit_timer.sv
// Bit-period timer: counts 1..rollover while enabled, strobes tc on the terminal count and wraps to 1.
// Latency: tc is combinational from the count; clr restarts at 1 so a new bit lasts exactly rollover cycles.
// Backpressure: none; en simply freezes the count.
module tx_bit_timer #(
    parameter int PERIOD_BITS = 14
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic                   clr,
    input  logic                   en,
    input  logic [PERIOD_BITS-1:0] rollover,
    output logic                   tc
);
    logic [PERIOD_BITS-1:0] count;

    // Terminal count: the current cycle is the last one of the bit.
    assign tc = en && !clr && (count >= rollover);

    // Count register: clr marks the first cycle of a new frame, wrap on terminal count.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count <= '0;
        end else if (clr) begin
            count <= PERIOD_BITS'(1);
        end else if (en) begin
            if (count >= rollover) begin
                count <= PERIOD_BITS'(1);
            end else begin
                count <= count + PERIOD_BITS'(1);
            end
        end
    end
endmodule

// File: rtl/uart_transmitter.sv
// UART transmit: frames one byte per accepted request as start, 5-8 data bits LSB first, optional even parity, stop.
// Latency: serial_out drops one cycle after accept; tx_done pulses (1+n+p+1)*bit_period+1 cycles after accept.
// Backpressure: tx_ready low for the whole frame; tx_start while busy is ignored, not queued.
module uart_transmitter #(
    parameter int PERIOD_BITS = 14,
    parameter int MAX_DATA    = 8
) (
    input  logic              clk,
    input  logic              n_rst,
    uart_transmitter_if.slave bus
);
    import uart_pkg::*;

    state_t                 state, state_nxt;
    logic [MAX_DATA-1:0]    sh_q, sh_nxt;
    logic [3:0]             size_q, size_nxt;
    logic [3:0]             cnt_q, cnt_nxt;
    logic [PERIOD_BITS-1:0] per_q, per_nxt;
    logic                   pen_q, pen_nxt;
    logic                   par_q, par_nxt;
    logic                   ser_q, ser_nxt;
    logic                   ready_q, busy_q;
    logic                   done_q, done_nxt;
    logic                   accept;
    logic                   tc;
    logic                   timer_en;
    logic [3:0]             size_cl;
    logic [PERIOD_BITS-1:0] per_cl;

    assign accept   = (state == IDLE) && bus.tx_start;
    assign timer_en = (state != IDLE);

    // Clamp the frame config at the input so only legal values are ever latched.
    always_comb begin
        size_cl = bus.data_size;
        if (bus.data_size < 4'(MIN_DATA)) begin
            size_cl = 4'(MIN_DATA);
        end else if (bus.data_size > 4'(MAX_DATA)) begin
            size_cl = 4'(MAX_DATA);
        end
        per_cl = (bus.bit_period == '0) ? PERIOD_BITS'(1) : bus.bit_period;
    end

    tx_bit_timer #(
        .PERIOD_BITS(PERIOD_BITS)
    ) u_bit_timer (
        .clk      (clk),
        .n_rst    (n_rst),
        .clr      (accept),
        .en       (timer_en),
        .rollover (per_q),
        .tc       (tc)
    );

    // Next-state and next-output: the line value is computed for the cycle after each bit boundary.
    always_comb begin
        state_nxt = state;
        sh_nxt    = sh_q;
        size_nxt  = size_q;
        per_nxt   = per_q;
        pen_nxt   = pen_q;
        cnt_nxt   = cnt_q;
        par_nxt   = par_q;
        ser_nxt   = ser_q;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                ser_nxt = IDLE_LEVEL;
                if (bus.tx_start) begin
                    sh_nxt    = bus.tx_data;
                    size_nxt  = size_cl;
                    per_nxt   = per_cl;
                    pen_nxt   = bus.parity_en;
                    cnt_nxt   = '0;
                    par_nxt   = 1'b0;
                    ser_nxt   = 1'b0;
                    state_nxt = START;
                end
            end
            START: begin
                if (tc) begin
                    ser_nxt   = sh_q[0];
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (tc) begin
                    par_nxt = par_q ^ sh_q[0];
                    sh_nxt  = sh_q >> 1;
                    if (cnt_q == size_q - 4'd1) begin
                        if (pen_q) begin
                            ser_nxt   = par_q ^ sh_q[0];
                            state_nxt = PARITY;
                        end else begin
                            ser_nxt   = 1'b1;
                            state_nxt = STOP;
                        end
                    end else begin
                        cnt_nxt = cnt_q + 4'd1;
                        ser_nxt = sh_nxt[0];
                    end
                end
            end
            PARITY: begin
                if (tc) begin
                    ser_nxt   = 1'b1;
                    state_nxt = STOP;
                end
            end
            STOP: begin
                if (tc) begin
                    ser_nxt   = IDLE_LEVEL;
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                ser_nxt   = IDLE_LEVEL;
                state_nxt = IDLE;
            end
        endcase
    end

    // State, frame latches and registered outputs; async reset aborts any frame silently.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state   <= IDLE;
            sh_q    <= '0;
            size_q  <= '0;
            per_q   <= '0;
            pen_q   <= 1'b0;
            cnt_q   <= '0;
            par_q   <= 1'b0;
            ser_q   <= IDLE_LEVEL;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            sh_q    <= sh_nxt;
            size_q  <= size_nxt;
            per_q   <= per_nxt;
            pen_q   <= pen_nxt;
            cnt_q   <= cnt_nxt;
            par_q   <= par_nxt;
            ser_q   <= ser_nxt;
            ready_q <= (state_nxt == IDLE);
            busy_q  <= (state_nxt != IDLE);
            done_q  <= done_nxt;
        end
    end

    assign bus.serial_out = ser_q;
    assign bus.tx_ready   = ready_q;
    assign bus.tx_busy    = busy_q;
    assign bus.tx_done    = done_q;
endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter: directed and random frames against a bit-list reference model.
// Latency: samples 1 time unit after each rising edge.
// Backpressure: exercises ignored tx_start while busy and held tx_start back-to-back.
module tb_uart_transmitter;
    logic clk = 1'b0;
    logic n_rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    uart_transmitter_if #(.PERIOD_BITS(14), .MAX_DATA(8)) bus ();

    uart_transmitter #(.PERIOD_BITS(14), .MAX_DATA(8)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // {serial_out, tx_ready, tx_busy, tx_done}
    function automatic logic [3:0] status();
        return {bus.serial_out, bus.tx_ready, bus.tx_busy, bus.tx_done};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_check(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            chk(tag, 32'(status()), 32'h0000_000c);
            step();
        end
    endtask

    // Sends one frame and checks every line cycle against the ideal bit list.
    // hold: leave tx_start high so the next call is accepted in the completion cycle.
    // perturb: mid-frame, change inputs and pulse tx_start; the frame must be unaffected.
    task automatic run_frame(input logic [7:0] d, input logic [3:0] sz, input logic [13:0] per,
                             input logic pe, input bit hold, input bit perturb, input string tag);
        int   n;
        int   p;
        int   len;
        logic par;
        logic bits[$];
        n = (sz < 5) ? 5 : ((sz > 8) ? 8 : int'(sz));
        p = (per == 0) ? 1 : int'(per);
        bits.delete();
        bits.push_back(1'b0);
        par = 1'b0;
        for (int k = 0; k < n; k++) begin
            bits.push_back(d[k]);
            par = par ^ d[k];
        end
        if (pe) bits.push_back(par);
        bits.push_back(1'b1);
        len = bits.size() * p;

        chk({tag, "_ready_before"}, 32'(bus.tx_ready), 32'd1);
        bus.tx_data    = d;
        bus.data_size  = sz;
        bus.bit_period = per;
        bus.parity_en  = pe;
        bus.tx_start   = 1'b1;
        step();
        bus.tx_start = hold;
        for (int i = 0; i < len; i++) begin
            if (perturb && i == len / 2) begin
                bus.tx_data    = 8'hFF;
                bus.bit_period = 14'd3;
                bus.data_size  = 4'd6;
                bus.parity_en  = ~pe;
                bus.tx_start   = 1'b1;
            end else if (perturb && i == len / 2 + 1) begin
                bus.tx_start = hold;
            end
            chk({tag, "_line"}, 32'(status()), 32'({bits[i / p], 3'b010}));
            step();
        end
        chk({tag, "_done"}, 32'(status()), 32'h0000_000d);
        if (!hold) begin
            step();
            chk({tag, "_after"}, 32'(status()), 32'h0000_000c);
        end
    endtask

    initial begin
        logic [7:0]  rd;
        logic [3:0]  rs;
        logic [13:0] rp;
        logic        rpe;
        bit          rh;
        string       rtag;

        bus.tx_data    = '0;
        bus.data_size  = 4'd8;
        bus.bit_period = 14'd10;
        bus.parity_en  = 1'b0;
        bus.tx_start   = 1'b0;

        // Reset values, during and after reset.
        n_rst = 1'b0;
        repeat (3) step();
        chk("reset_hold", 32'(status()), 32'h0000_000c);
        n_rst = 1'b1;
        step();
        chk("reset_release", 32'(status()), 32'h0000_000c);

        run_frame(8'hA5, 4'd8, 14'd10, 1'b0, 1'b0, 1'b0, "a5_8n");
        run_frame(8'h13, 4'd5, 14'd4,  1'b1, 1'b0, 1'b0, "13_5p");

        // Busy request with changed config: ignored, no second frame.
        run_frame(8'h3C, 4'd8, 14'd6, 1'b1, 1'b0, 1'b1, "busy_cfg");
        idle_check("no_second_frame", 30);

        // Back-to-back at minimum period with tx_start held.
        run_frame(8'h00, 4'd8, 14'd1, 1'b0, 1'b1, 1'b0, "b2b_first");
        run_frame(8'hFF, 4'd8, 14'd1, 1'b0, 1'b0, 1'b0, "b2b_second");

        // Clamping of data_size and bit_period.
        run_frame(8'hF6, 4'd2,  14'd3, 1'b0, 1'b0, 1'b0, "size_lo");
        run_frame(8'h81, 4'd12, 14'd2, 1'b1, 1'b0, 1'b0, "size_hi");
        run_frame(8'h5A, 4'd7,  14'd0, 1'b1, 1'b0, 1'b0, "period0");

        // Reset in the middle of a frame: line high at once, no completion pulse.
        bus.tx_data    = 8'h00;
        bus.data_size  = 4'd8;
        bus.bit_period = 14'd10;
        bus.parity_en  = 1'b0;
        bus.tx_start   = 1'b1;
        step();
        bus.tx_start = 1'b0;
        repeat (15) step();
        chk("mid_frame_low", 32'(status()), 32'h0000_0002);
        #2;
        n_rst = 1'b0;
        #1;
        chk("mid_reset_async", 32'(status()), 32'h0000_000c);
        step();
        step();
        n_rst = 1'b1;
        step();
        idle_check("after_mid_reset", 20);

        // Random frames, some chained with tx_start held.
        for (int f = 0; f < 12; f++) begin
            rd   = 8'($urandom);
            rs   = 4'($urandom_range(0, 15));
            rp   = 14'($urandom_range(0, 6));
            rpe  = 1'($urandom_range(0, 1));
            rh   = (f == 11) ? 1'b0 : 1'($urandom_range(0, 1));
            rtag = $sformatf("rand%0d", f);
            run_frame(rd, rs, rp, rpe, rh, 1'b0, rtag);
        end
        idle_check("final_idle", 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
